// File: rtl/time_base_pkg.sv
// Shared definitions for the modul_time_base time base.
//   state_e    : PPS discipline state encoding.
//   early_lo() : lowest ctr_us value accepted as an early PPS edge. The late
//                bound is PPS_TOL itself.
//   params_ok(): legality of a parameter set. PPS_TOL must leave t1us phases
//                of at least 2 cycles after any in-window realign.
package time_base_pkg;

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOVER = 2'd3
    } state_e;

    function automatic int early_lo(input int clk_per_us, input int pps_tol);
        return clk_per_us - 1 - pps_tol;
    endfunction

    function automatic bit params_ok(input int clk_per_us, input int us_per_ms,
                                     input int ms_per_s, input int pps_tol);
        return ((clk_per_us % 2) == 0) && (clk_per_us >= 8) &&
               (us_per_ms >= 1) && (ms_per_s >= 1) &&
               (pps_tol >= 0) && (pps_tol <= (clk_per_us / 2) - 2);
    endfunction

endpackage

// File: rtl/pps_sync_edge.sv
// Two-flop synchronizer for the asynchronous 1PPS input, followed by a
// registered rising-edge detector. Input rise to edge_o is 3 clk cycles.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   pps_i  : raw 1PPS input, asynchronous to clk_i
//   edge_o : one-cycle pulse per rising edge of pps_i
module pps_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pps_i,
    output logic edge_o
);

    logic sync_p0_q;
    logic sync_p1_q;
    logic sync_p2_q;
    logic edge_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_p0_q <= 1'b0;
            sync_p1_q <= 1'b0;
            sync_p2_q <= 1'b0;
            edge_q    <= 1'b0;
        end else begin
            sync_p0_q <= pps_i;
            sync_p1_q <= sync_p0_q;
            sync_p2_q <= sync_p1_q;
            edge_q    <= sync_p1_q & ~sync_p2_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/modul_time_base.sv
// Master time base: divides clk into a 1 us square wave, 1 ms / 1 s strobes
// and a running seconds count, optionally disciplined to an external 1PPS.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   pps_in  : external 1PPS, asynchronous, rising edge significant
//   sync_en : enables PPS discipline
//   t1us    : 1 us square wave, ~50 % duty
//   t1ms    : one-cycle strobe per ms
//   t1s     : one-cycle strobe per s
//   sec_cnt : seconds elapsed, wraps
//   locked  : high while in the LOCKED state
//   pps_err : one-cycle strobe when a PPS edge is rejected
module modul_time_base
    import time_base_pkg::*;
#(
    parameter int CLK_PER_US = 100,
    parameter int US_PER_MS  = 1000,
    parameter int MS_PER_S   = 1000,
    parameter int PPS_TOL    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pps_in,
    input  logic        sync_en,
    output logic        t1us,
    output logic        t1ms,
    output logic        t1s,
    output logic [31:0] sec_cnt,
    output logic        locked,
    output logic        pps_err
);

    if (!params_ok(CLK_PER_US, US_PER_MS, MS_PER_S, PPS_TOL)) begin : g_bad_params
        $error("modul_time_base: illegal CLK_PER_US/US_PER_MS/MS_PER_S/PPS_TOL");
    end

    localparam int CW = $clog2(CLK_PER_US);
    localparam int UW = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;
    localparam int MW = (MS_PER_S > 1) ? $clog2(MS_PER_S) : 1;

    localparam logic [CW-1:0] CTR_LAST  = CW'(CLK_PER_US - 1);
    localparam logic [CW-1:0] CTR_HALF  = CW'(CLK_PER_US / 2);
    localparam logic [CW-1:0] CTR_EARLY = CW'(early_lo(CLK_PER_US, PPS_TOL));
    localparam logic [CW-1:0] CTR_LATE  = CW'(PPS_TOL);
    localparam logic [UW-1:0] US_LAST   = UW'(US_PER_MS - 1);
    localparam logic [MW-1:0] MS_LAST   = MW'(MS_PER_S - 1);

    logic [CW-1:0] ctr_us_q, ctr_us_d;
    logic [UW-1:0] us_in_ms_q, us_in_ms_d;
    logic [MW-1:0] ms_in_s_q, ms_in_s_d;
    logic [31:0]   sec_q, sec_d;
    logic          t1us_q, t1ms_q, t1s_q, pps_err_q, locked_q;
    state_e        state_q, state_d;
    logic [1:0]    miss_q, miss_d;

    logic pps_edge;
    logic us_wrap, ms_wrap, s_wrap;
    logic early_win, late_win, in_win;
    logic realign, reject, fire_new, ms_fire, s_fire;

    pps_sync_edge u_pps_sync_edge (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .pps_i  (pps_in),
        .edge_o (pps_edge)
    );

    assign us_wrap = (ctr_us_q == CTR_LAST);
    assign ms_wrap = us_wrap && (us_in_ms_q == US_LAST);
    assign s_wrap  = ms_wrap && (ms_in_s_q == MS_LAST);

    // Edge window straddles the second boundary: the tail of the last us of
    // the second (early) or the head of the first us of the next (late).
    assign early_win = (ms_in_s_q == MS_LAST) && (us_in_ms_q == US_LAST) &&
                       (ctr_us_q >= CTR_EARLY);
    assign late_win  = (ms_in_s_q == '0) && (us_in_ms_q == '0) &&
                       (ctr_us_q <= CTR_LATE);
    assign in_win    = early_win | late_win;

    always_comb begin
        state_d = state_q;
        miss_d  = (state_q == ST_LOCKED) ? miss_q : 2'd0;
        realign = 1'b0;
        reject  = 1'b0;
        if (!sync_en) begin
            state_d = ST_FREE;
        end else begin
            case (state_q)
                ST_FREE: begin
                    if (pps_edge) begin
                        realign = 1'b1;
                        state_d = ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (pps_edge) begin
                        realign = 1'b1;
                        if (in_win) state_d = ST_LOCKED;
                        else        reject  = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (pps_edge && in_win) begin
                        realign = 1'b1;
                        miss_d  = 2'd0;
                    end else if (pps_edge) begin
                        reject  = 1'b1;
                        state_d = ST_ACQUIRE;
                    end else if (miss_q == 2'd2) begin
                        state_d = ST_HOLDOVER;
                    end else if (s_wrap) begin
                        miss_d = miss_q + 2'd1;
                    end
                end
                ST_HOLDOVER: begin
                    if (pps_edge) begin
                        if (in_win) begin
                            realign = 1'b1;
                            state_d = ST_LOCKED;
                        end else begin
                            reject  = 1'b1;
                            state_d = ST_ACQUIRE;
                        end
                    end
                end
                default: state_d = ST_FREE;
            endcase
        end
    end

    // A late-window realign lands just after a boundary that already fired,
    // so only other realigns open a new second. A realign coincident with
    // the natural wrap produces a single strobe.
    assign fire_new = realign & ~late_win;
    assign ms_fire  = ms_wrap | fire_new;
    assign s_fire   = s_wrap | fire_new;

    always_comb begin
        ctr_us_d   = us_wrap ? '0 : ctr_us_q + 1'b1;
        us_in_ms_d = us_in_ms_q;
        ms_in_s_d  = ms_in_s_q;
        if (us_wrap) us_in_ms_d = (us_in_ms_q == US_LAST) ? '0 : us_in_ms_q + 1'b1;
        if (ms_wrap) ms_in_s_d  = (ms_in_s_q == MS_LAST) ? '0 : ms_in_s_q + 1'b1;
        if (realign) begin
            ctr_us_d   = '0;
            us_in_ms_d = '0;
            ms_in_s_d  = '0;
        end
        sec_d = s_fire ? sec_q + 32'd1 : sec_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_us_q   <= '0;
            us_in_ms_q <= '0;
            ms_in_s_q  <= '0;
            sec_q      <= '0;
            t1us_q     <= 1'b0;
            t1ms_q     <= 1'b0;
            t1s_q      <= 1'b0;
            pps_err_q  <= 1'b0;
            locked_q   <= 1'b0;
            state_q    <= ST_FREE;
            miss_q     <= 2'd0;
        end else begin
            ctr_us_q   <= ctr_us_d;
            us_in_ms_q <= us_in_ms_d;
            ms_in_s_q  <= ms_in_s_d;
            sec_q      <= sec_d;
            t1us_q     <= (ctr_us_q < CTR_HALF);
            t1ms_q     <= ms_fire;
            t1s_q      <= s_fire;
            pps_err_q  <= reject;
            locked_q   <= (state_q == ST_LOCKED);
            state_q    <= state_d;
            miss_q     <= miss_d;
        end
    end

    assign t1us    = t1us_q;
    assign t1ms    = t1ms_q;
    assign t1s     = t1s_q;
    assign sec_cnt = sec_q;
    assign locked  = locked_q;
    assign pps_err = pps_err_q;

endmodule

// File: tb/tb_modul_time_base.sv
// Directed bench for modul_time_base with CLK_PER_US=10, US_PER_MS=4,
// MS_PER_S=5, PPS_TOL=3 (200 clk per second). n counts rising clk edges
// since the last reset release; outputs are sampled on the falling edge.
// A pps_in rise driven at the falling edge of cycle r shows up as t1s at
// cycle r+4 for a realign at the wrap, or r+2 for a late realign by 2.
module tb_modul_time_base;
    import time_base_pkg::*;

    localparam int CPU = 10;
    localparam int UPM = 4;
    localparam int MPS = 5;
    localparam int TOL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pps_in = 1'b0;
    logic        sync_en = 1'b0;
    logic        t1us, t1ms, t1s, locked, pps_err;
    logic [31:0] sec_cnt;

    int n = 0;
    int pass_cnt = 0;
    int total_cnt = 0;
    int rises[8];
    int nrises = 0;

    modul_time_base #(
        .CLK_PER_US (CPU),
        .US_PER_MS  (UPM),
        .MS_PER_S   (MPS),
        .PPS_TOL    (TOL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pps_in  (pps_in),
        .sync_en (sync_en),
        .t1us    (t1us),
        .t1ms    (t1ms),
        .t1s     (t1s),
        .sec_cnt (sec_cnt),
        .locked  (locked),
        .pps_err (pps_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // PPS pulses are 20 cycles wide starting at each scheduled rise.
    function automatic logic pps_at(input int t);
        logic v;
        v = 1'b0;
        for (int i = 0; i < nrises; i++)
            if (t >= rises[i] && t < rises[i] + 20) v = 1'b1;
        return v;
    endfunction

    function automatic logic is_rise(input int t);
        logic v;
        v = 1'b0;
        for (int i = 0; i < nrises; i++)
            if (t == rises[i]) v = 1'b1;
        return v;
    endfunction

    task automatic tick();
        pps_in = pps_at(n);
        @(negedge clk);
        n++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sync_en = 1'b0; pps_in = 1'b0; nrises = 0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({t1us, t1ms, t1s, locked, pps_err} !== 5'b0 || sec_cnt !== 32'd0)
            $display("FAIL reset_outputs: got t1us/t1ms/t1s/locked/pps_err=%b sec=%0d, required 0",
                     {t1us, t1ms, t1s, locked, pps_err}, sec_cnt);
        else pass_cnt++;
        total_cnt++;
        if (dut.state_q !== ST_FREE)
            $display("FAIL reset_state: got %0d, required %0d", dut.state_q, ST_FREE);
        else pass_cnt++;
        rst_n = 1'b1;
        n = 0;
        tick();
        total_cnt++;
        if (t1us !== 1'b1) $display("FAIL first_t1us: got %b, required 1", t1us);
        else pass_cnt++;
    endtask

    task automatic test_free_run();
        int us_bad = 0, ms_bad = 0, s_bad = 0, lk_hi = 0, err_hi = 0;
        rises[0] = 77; rises[1] = 500; nrises = 2;
        while (n < 1000) begin
            tick();
            if (t1us !== logic'(((n - 1) % CPU) < (CPU / 2))) us_bad++;
            if (t1ms !== logic'((n % 40) == 0)) ms_bad++;
            if (t1s !== logic'((n % 200) == 0)) s_bad++;
            if (locked !== 1'b0) lk_hi++;
            if (pps_err !== 1'b0) err_hi++;
        end
        total_cnt++;
        if (us_bad != 0) $display("FAIL free_t1us: %0d bad cycles, required 0", us_bad); else pass_cnt++;
        total_cnt++;
        if (ms_bad != 0) $display("FAIL free_t1ms: %0d bad cycles, required 0", ms_bad); else pass_cnt++;
        total_cnt++;
        if (s_bad != 0) $display("FAIL free_t1s: %0d bad cycles, required 0", s_bad); else pass_cnt++;
        total_cnt++;
        if (sec_cnt !== 32'd5) $display("FAIL free_sec_cnt: got %0d, required 5", sec_cnt); else pass_cnt++;
        total_cnt++;
        if (lk_hi != 0 || err_hi != 0)
            $display("FAIL free_locked_err: locked-high %0d err-high %0d, required 0/0", lk_hi, err_hi);
        else pass_cnt++;
    endtask

    task automatic test_lock_acquire();
        int s_bad = 0, err_hi = 0;
        sync_en = 1'b1;
        rises[0] = 1037; rises[1] = 1237; rises[2] = 1437; rises[3] = 1637; nrises = 4;
        while (n < 1700) begin
            tick();
            if (t1s !== is_rise(n - 4)) s_bad++;
            if (pps_err !== 1'b0) err_hi++;
            if (n == 1042) begin
                total_cnt++;
                if (dut.state_q !== ST_ACQUIRE || locked !== 1'b0)
                    $display("FAIL acq_after_first: state %0d locked %b, required %0d/0",
                             dut.state_q, locked, ST_ACQUIRE);
                else pass_cnt++;
            end
            if (n == 1241) begin
                total_cnt++;
                if (locked !== 1'b0) $display("FAIL acq_locked_early: got %b, required 0", locked);
                else pass_cnt++;
            end
            if (n == 1242) begin
                total_cnt++;
                if (locked !== 1'b1) $display("FAIL acq_locked: got %b, required 1", locked);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (s_bad != 0) $display("FAIL acq_t1s_latency: %0d bad cycles, required 0", s_bad); else pass_cnt++;
        total_cnt++;
        if (err_hi != 0) $display("FAIL acq_pps_err: %0d pulses, required 0", err_hi); else pass_cnt++;
        total_cnt++;
        if (sec_cnt !== 32'd9) $display("FAIL acq_sec_cnt: got %0d, required 9", sec_cnt); else pass_cnt++;
    endtask

    task automatic test_drift();
        int s_bad = 0, err_hi = 0, lk_lo = 0, run_bad = 0, stretched = 0;
        int run_start = 0;
        logic prev;
        rises[0] = 1839; rises[1] = 2041; rises[2] = 2243; rises[3] = 2445; nrises = 4;
        prev = t1us;
        while (n < 2500) begin
            tick();
            if (t1s !== is_rise(n - 2)) s_bad++;
            if (pps_err !== 1'b0) err_hi++;
            if (locked !== 1'b1) lk_lo++;
            if (!prev && t1us) run_start = n;
            if (prev && !t1us && run_start > 0) begin
                if ((n - run_start) != (is_rise(run_start - 3) ? 7 : 5)) run_bad++;
                if ((n - run_start) == 7) stretched++;
            end
            prev = t1us;
        end
        total_cnt++;
        if (s_bad != 0) $display("FAIL drift_t1s: %0d bad cycles, required 0", s_bad); else pass_cnt++;
        total_cnt++;
        if (run_bad != 0 || stretched != 4)
            $display("FAIL drift_t1us_high: %0d bad runs, %0d stretched, required 0/4", run_bad, stretched);
        else pass_cnt++;
        total_cnt++;
        if (err_hi != 0 || lk_lo != 0)
            $display("FAIL drift_lock: err %0d unlocked %0d, required 0/0", err_hi, lk_lo);
        else pass_cnt++;
        total_cnt++;
        if (sec_cnt !== 32'd13) $display("FAIL drift_sec_cnt: got %0d, required 13", sec_cnt); else pass_cnt++;
    endtask

    task automatic test_jump();
        int s_bad = 0, err_bad = 0;
        rises[0] = 2645; rises[1] = 2895; rises[2] = 3045; nrises = 3;
        while (n < 3100) begin
            tick();
            if (t1s !== logic'(n == 2649 || n == 2849 || n == 3049)) s_bad++;
            if (pps_err !== logic'(n == 2899)) err_bad++;
            if (n == 2899 || n == 2900 || n == 3049 || n == 3050) begin
                total_cnt++;
                if (locked !== logic'(n == 2899 || n == 3050))
                    $display("FAIL jump_locked_at_%0d: got %b, required %b", n, locked,
                             logic'(n == 2899 || n == 3050));
                else pass_cnt++;
            end
            if (n == 2950) begin
                total_cnt++;
                if (dut.state_q !== ST_ACQUIRE)
                    $display("FAIL jump_state: got %0d, required %0d", dut.state_q, ST_ACQUIRE);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (s_bad != 0) $display("FAIL jump_t1s: %0d bad cycles, required 0", s_bad); else pass_cnt++;
        total_cnt++;
        if (err_bad != 0) $display("FAIL jump_pps_err: %0d bad cycles, required 0", err_bad); else pass_cnt++;
        total_cnt++;
        if (sec_cnt !== 32'd16) $display("FAIL jump_sec_cnt: got %0d, required 16", sec_cnt); else pass_cnt++;
    endtask

    task automatic test_holdover();
        int s_bad = 0, err_hi = 0;
        rises[0] = 3845; nrises = 1;
        while (n < 3900) begin
            tick();
            if (t1s !== logic'(n == 3249 || n == 3449 || n == 3649 || n == 3849)) s_bad++;
            if (pps_err !== 1'b0) err_hi++;
            if (n == 3450 || n == 3451 || n == 3849 || n == 3850) begin
                total_cnt++;
                if (locked !== logic'(n == 3450 || n == 3850))
                    $display("FAIL hold_locked_at_%0d: got %b, required %b", n, locked,
                             logic'(n == 3450 || n == 3850));
                else pass_cnt++;
            end
            if (n == 3500) begin
                total_cnt++;
                if (dut.state_q !== ST_HOLDOVER)
                    $display("FAIL hold_state: got %0d, required %0d", dut.state_q, ST_HOLDOVER);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (s_bad != 0) $display("FAIL hold_t1s: %0d bad cycles, required 0", s_bad); else pass_cnt++;
        total_cnt++;
        if (err_hi != 0) $display("FAIL hold_pps_err: %0d pulses, required 0", err_hi); else pass_cnt++;
        total_cnt++;
        if (sec_cnt !== 32'd20) $display("FAIL hold_sec_cnt: got %0d, required 20", sec_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int rst_bad = 0, us_bad = 0, ms_bad = 0, s_bad = 0, sec_bad = 0, lk_hi = 0;
        nrises = 0;
        repeat (60) tick();
        rst_n = 1'b0;
        pps_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if ({t1us, t1ms, t1s, locked, pps_err} !== 5'b0 || sec_cnt !== 32'd0) rst_bad++;
        end
        total_cnt++;
        if (rst_bad != 0) $display("FAIL mid_reset_outputs: %0d bad cycles, required 0", rst_bad);
        else pass_cnt++;
        rst_n = 1'b1;
        n = 0;
        while (n < 220) begin
            tick();
            if (t1us !== logic'(((n - 1) % CPU) < (CPU / 2))) us_bad++;
            if (t1ms !== logic'((n % 40) == 0)) ms_bad++;
            if (t1s !== logic'(n == 200)) s_bad++;
            if (sec_cnt !== ((n >= 200) ? 32'd1 : 32'd0)) sec_bad++;
            if (locked !== 1'b0) lk_hi++;
        end
        total_cnt++;
        if (us_bad != 0 || ms_bad != 0)
            $display("FAIL mid_restart_us_ms: t1us %0d t1ms %0d bad cycles, required 0/0", us_bad, ms_bad);
        else pass_cnt++;
        total_cnt++;
        if (s_bad != 0 || sec_bad != 0)
            $display("FAIL mid_restart_s: t1s %0d sec_cnt %0d bad cycles, required 0/0", s_bad, sec_bad);
        else pass_cnt++;
        total_cnt++;
        if (dut.state_q !== ST_FREE || lk_hi != 0)
            $display("FAIL mid_state: state %0d locked-high %0d, required %0d/0", dut.state_q, lk_hi, ST_FREE);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_lock_acquire();
        test_drift();
        test_jump();
        test_holdover();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/modul_time_base.md
# modul_time_base

Master time base for the test board. It divides the system clock into a 1 µs square wave `t1us` that feeds the 5-minute interval counter, plus single-cycle `t1ms`/`t1s` strobes and a running seconds count. When enabled, the second boundary is disciplined to an external 1PPS input, with lock and holdover tracking.

## Interface
- `CLK_PER_US`, default 100: clk cycles per µs; even, ≥ 8.
- `US_PER_MS`, default 1000: µs per ms.
- `MS_PER_S`, default 1000: ms per s.
- `PPS_TOL`, default 3: PPS acceptance half-window in clk cycles; must be ≤ CLK_PER_US/2 − 2.
- `clk` in 1: system clock; the single clock of the block.
- `rst_n` in 1: reset, asynchronous and active-low.
- `pps_in` in 1: external 1PPS, asynchronous to `clk`, rising edge significant.
- `sync_en` in 1: enables PPS discipline; static or quasi-static.
- `t1us` out 1: 1 µs square wave, nominally 50 % duty.
- `t1ms` out 1: one-cycle strobe per ms.
- `t1s` out 1: one-cycle strobe per s.
- `sec_cnt` out 32: seconds elapsed, wraps.
- `locked` out 1: high in LOCKED state.
- `pps_err` out 1: one-cycle strobe when a PPS edge is rejected.

## Operation
- **Counters.**
  - `ctr_us` counts 0..CLK_PER_US−1.
  - `us_in_ms` counts 0..US_PER_MS−1 and advances when `ctr_us` wraps.
  - `ms_in_s` counts 0..MS_PER_S−1 and advances when `us_in_ms` wraps.
- **Strobes.**
  - `t1us` = registered (`ctr_us` < CLK_PER_US/2).
  - `t1ms` pulses on the cycle `us_in_ms` wraps.
  - `t1s` pulses on the cycle `ms_in_s` wraps.
  - `sec_cnt` increments on each `t1s`; 0xFFFFFFFF wraps to 0.
- **PPS input.** `pps_in` passes through a 2-FF synchronizer, then a rising-edge detector producing `pps_edge`.
- **Window.** A PPS edge is in-window when either:
  - early: `ms_in_s`=MS_PER_S−1, `us_in_ms`=US_PER_MS−1 and `ctr_us` ≥ CLK_PER_US−1−PPS_TOL; or
  - late: all three counters are 0 and `ctr_us` ≤ PPS_TOL.
- **Realign on an accepted edge.**
  - All three counters load 0 on the next cycle.
  - Early edge: `t1ms`/`t1s`/`sec_cnt`++ fire on the edge cycle, and the natural boundary is suppressed.
  - Late edge: the boundary has already fired, so only the counters reload.
  - Result: exactly one `t1s` per second.
- **State machine** (state `miss` = count of consecutive `t1s` without a PPS edge):
  - FREE: entered on reset or `sync_en`=0. No realign. The first `pps_edge` with `sync_en`=1 realigns unconditionally → ACQUIRE.
  - ACQUIRE: in-window edge → realign, go to LOCKED. Out-of-window edge → realign, `pps_err`, stay in ACQUIRE.
  - LOCKED: in-window edge → realign, clear `miss`. Out-of-window edge → `pps_err`, no realign, go to ACQUIRE. `miss`=2 → HOLDOVER.
  - HOLDOVER: free-running. In-window edge → realign, go to LOCKED. Out-of-window edge → `pps_err`, go to ACQUIRE.
  - Any state with `sync_en`=0 → FREE next cycle; counters continue running.
- **Reset values.** All counters 0, `sec_cnt`=0, `t1us`/`t1ms`/`t1s`/`pps_err`/`locked` = 0, state FREE. Reset mid-second discards phase.

## Timing
- PPS latency: `pps_in` rise to `pps_edge` is 3 clk cycles; the realign load takes effect 1 cycle after `pps_edge`.
- `t1us` lags `ctr_us` by 1 cycle. The first `t1us` high occurs on the 1st cycle after `rst_n` deasserts.
- `t1us` high and low phases are each ≥ 2 cycles under every realign, as guaranteed by the PPS_TOL bound. This is required because the downstream consumer detects edges on a 3-stage shift (pattern 011).
- `t1ms` and `t1s` are coincident with the `t1us` rising edge that starts the new ms/s, ±1 cycle.
- `pps_edge` coinciding with the natural wrap counts as early: a single `t1s` fires.
- `locked` rises 1 cycle after the state enters LOCKED.

## Structure
- Shared package `time_base_pkg` holds:
  - the state encoding enum (FREE, ACQUIRE, LOCKED, HOLDOVER);
  - a localparam helper for the window bounds;
  - the compile-time checks on parameter constraints.
- Natural sub-module: `pps_sync_edge` (2-FF synchronizer plus rising-edge detector).

## Test plan
All cases use CLK_PER_US=10, US_PER_MS=4, MS_PER_S=5, PPS_TOL=3, i.e. 200 clk per s.
- Free run, `sync_en`=0, 1000 cycles:
  - `t1us` period 10, high 5;
  - `t1ms` every 40 cycles;
  - `t1s` every 200 cycles;
  - `sec_cnt`=5;
  - `locked`=0.
- Lock acquire, `sync_en`=1, PPS every 200 cycles, arbitrary start phase:
  - ACQUIRE after the 1st edge, `locked`=1 after the 2nd;
  - `t1s` exactly 4 cycles after each `pps_in` rise;
  - no `pps_err`.
- Drift, PPS period 202 while locked:
  - each second realigns late, with `t1us` high stretched to 7;
  - one `t1s` per PPS;
  - no `pps_err`.
- Out-of-window jump, PPS shifted by 50 cycles while locked:
  - `pps_err` 1 cycle;
  - ACQUIRE, then LOCKED on the following edge.
- Holdover, PPS stopped while locked:
  - HOLDOVER after 2 `t1s`, with `t1s` continuing every 200 cycles;
  - PPS resumed in-window → LOCKED.
- Reset asserted mid-second, then released:
  - all outputs 0 while `rst_n`=0;
  - counting restarts from 0;
  - `sec_cnt`=0;
  - state FREE.
